// File: rtl/pulse_scan_ctrl_if.sv
// ============================================================
// pulse_scan_ctrl_if - scan control/status bundle for pulse_scan_ctrl (Rev 1.0)
// ============================================================
`default_nettype none

interface pulse_scan_ctrl_if #(
    parameter int NUM_CH = 4
) ();
    localparam int c_ch_w = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              enable;
    logic [NUM_CH-1:0] rxd;
    logic [c_ch_w-1:0] ch_sel;
    logic [NUM_CH-1:0] sys_Stat;
    logic [NUM_CH-1:0] Pulse_err;
    logic              scan_done;

    modport master (
        output enable,
        output rxd,
        input  ch_sel,
        input  sys_Stat,
        input  Pulse_err,
        input  scan_done
    );

    modport slave (
        input  enable,
        input  rxd,
        output ch_sel,
        output sys_Stat,
        output Pulse_err,
        output scan_done
    );
endinterface

`default_nettype wire

// File: rtl/pulse_scan_ctrl.sv
// ============================================================
// pulse_scan_ctrl - round-robin period classifier sharing one counter over NUM_CH lines
// Rev 1.0
// ============================================================
`default_nettype none

module pulse_scan_ctrl #(
    parameter int          NUM_CH   = 4,
    parameter int          PULSENUM = 2,
    parameter int          F1M_L    = PULSENUM * 19,
    parameter int          F1M_H    = PULSENUM * 21,
    parameter int          F10K_L   = PULSENUM * 1900,
    parameter int          F10K_H   = PULSENUM * 2100,
    parameter logic [17:0] TIMEOUT  = 18'h3ffff
) (
    input  wire logic        clk_20M,
    input  wire logic        reset_n,
    pulse_scan_ctrl_if.slave bus
);
    localparam int                  c_ch_w       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int                  c_edge_w     = $clog2(PULSENUM + 1);
    localparam logic [17:0]         c_cnt_max    = 18'h3ffff;
    localparam logic [c_ch_w-1:0]   c_last_ch    = c_ch_w'(NUM_CH - 1);
    localparam logic [c_edge_w-1:0] c_edges_done = c_edge_w'(PULSENUM);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_MEAS  = 3'd2,
        S_JUDGE = 3'd3,
        S_NEXT  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_ch_w-1:0]   r_ch_sel;
    logic [c_ch_w-1:0]   w_ch_sel_nxt;
    logic [NUM_CH-1:0]   r_sys_stat;
    logic [NUM_CH-1:0]   w_sys_stat_nxt;
    logic [NUM_CH-1:0]   r_pulse_err;
    logic [NUM_CH-1:0]   w_pulse_err_nxt;
    logic                r_scan_done;
    logic                w_scan_done_nxt;
    logic [17:0]         r_tmo;
    logic [17:0]         w_tmo_nxt;
    logic [17:0]         r_cnt;
    logic [17:0]         w_cnt_nxt;
    logic [c_edge_w-1:0] r_edges;
    logic [c_edge_w-1:0] w_edges_nxt;
    logic                r_fault;
    logic                w_fault_nxt;
    logic                r_prev;
    logic                w_prev_nxt;

    logic                w_line;
    logic                w_rise;
    logic [c_edge_w-1:0] w_edges_inc;
    logic [17:0]         w_cnt_inc;
    logic                w_tmo_hit;
    logic                w_in_1m;
    logic                w_in_10k;

    assign w_line      = bus.rxd[r_ch_sel];
    assign w_rise      = w_line & ~r_prev;
    assign w_edges_inc = r_edges + c_edge_w'(1);
    assign w_cnt_inc   = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 18'd1;
    assign w_tmo_hit   = (r_tmo == TIMEOUT);
    assign w_in_1m     = (r_cnt >= 18'(F1M_L))  && (r_cnt <= 18'(F1M_H));
    assign w_in_10k    = (r_cnt >= 18'(F10K_L)) && (r_cnt <= 18'(F10K_H));

    always_ff @(posedge clk_20M) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ch_sel_nxt    = r_ch_sel;
        w_sys_stat_nxt  = r_sys_stat;
        w_pulse_err_nxt = r_pulse_err;
        w_scan_done_nxt = 1'b0;
        w_tmo_nxt       = r_tmo;
        w_cnt_nxt       = r_cnt;
        w_edges_nxt     = r_edges;
        w_fault_nxt     = r_fault;
        w_prev_nxt      = w_line;

        case (r_state)
            S_IDLE: begin
                w_tmo_nxt   = '0;
                w_cnt_nxt   = '0;
                w_edges_nxt = '0;
                w_fault_nxt = 1'b0;
                if (bus.enable) begin
                    w_state_nxt = S_ARM;
                    w_prev_nxt  = 1'b1;
                end
            end

            S_ARM: begin
                w_tmo_nxt = r_tmo + 18'd1;
                if (!bus.enable) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_JUDGE;
                    w_fault_nxt = 1'b1;
                end else if (w_rise) begin
                    w_state_nxt = S_MEAS;
                    w_cnt_nxt   = '0;
                    w_edges_nxt = '0;
                end
            end

            S_MEAS: begin
                w_tmo_nxt = r_tmo + 18'd1;
                w_cnt_nxt = w_cnt_inc;
                if (!bus.enable) begin
                    w_state_nxt = S_IDLE;
                end else if (w_rise && (w_edges_inc == c_edges_done)) begin
                    // A finished measurement outranks a timeout landing on the same cycle.
                    w_state_nxt = S_JUDGE;
                    w_edges_nxt = w_edges_inc;
                    w_fault_nxt = 1'b0;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_JUDGE;
                    w_fault_nxt = 1'b1;
                end else if (w_rise) begin
                    w_edges_nxt = w_edges_inc;
                end
            end

            S_JUDGE: begin
                if (!bus.enable) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_NEXT;
                    if (r_fault) begin
                        w_sys_stat_nxt[r_ch_sel]  = 1'b0;
                        w_pulse_err_nxt[r_ch_sel] = 1'b1;
                    end else if (w_in_1m) begin
                        w_sys_stat_nxt[r_ch_sel]  = 1'b1;
                        w_pulse_err_nxt[r_ch_sel] = 1'b0;
                    end else if (w_in_10k) begin
                        w_sys_stat_nxt[r_ch_sel]  = 1'b0;
                        w_pulse_err_nxt[r_ch_sel] = 1'b0;
                    end else begin
                        w_sys_stat_nxt[r_ch_sel]  = 1'b0;
                        w_pulse_err_nxt[r_ch_sel] = 1'b1;
                    end
                end
            end

            S_NEXT: begin
                w_tmo_nxt   = '0;
                w_cnt_nxt   = '0;
                w_edges_nxt = '0;
                w_fault_nxt = 1'b0;
                if (r_ch_sel == c_last_ch) begin
                    w_ch_sel_nxt    = '0;
                    w_scan_done_nxt = 1'b1;
                end else begin
                    w_ch_sel_nxt = r_ch_sel + c_ch_w'(1);
                end
                if (bus.enable) begin
                    w_state_nxt = S_ARM;
                    w_prev_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_20M) begin
        if (!reset_n) begin
            r_ch_sel    <= '0;
            r_sys_stat  <= '0;
            r_pulse_err <= '0;
            r_scan_done <= 1'b0;
            r_tmo       <= '0;
            r_cnt       <= '0;
            r_edges     <= '0;
            r_fault     <= 1'b0;
            r_prev      <= 1'b1;
        end else begin
            r_ch_sel    <= w_ch_sel_nxt;
            r_sys_stat  <= w_sys_stat_nxt;
            r_pulse_err <= w_pulse_err_nxt;
            r_scan_done <= w_scan_done_nxt;
            r_tmo       <= w_tmo_nxt;
            r_cnt       <= w_cnt_nxt;
            r_edges     <= w_edges_nxt;
            r_fault     <= w_fault_nxt;
            r_prev      <= w_prev_nxt;
        end
    end

    assign bus.ch_sel    = r_ch_sel;
    assign bus.sys_Stat  = r_sys_stat;
    assign bus.Pulse_err = r_pulse_err;
    assign bus.scan_done = r_scan_done;

endmodule

`default_nettype wire

// File: tb/tb_pulse_scan_ctrl.sv
// ============================================================
// tb_pulse_scan_ctrl - scoreboard bench: directed line patterns, results checked on each channel advance
// Rev 1.0
// ============================================================
`default_nettype none

module tb_pulse_scan_ctrl;
    localparam int NCH = 4;

    logic clk_20M = 1'b0;
    logic reset_n = 1'b0;
    always #25 clk_20M = ~clk_20M;

    pulse_scan_ctrl_if #(.NUM_CH(NCH)) bus ();

    pulse_scan_ctrl #(
        .NUM_CH  (NCH),
        .PULSENUM(2),
        .TIMEOUT (18'd8000)
    ) dut (
        .clk_20M(clk_20M),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        int         ch;
        logic [3:0] sys;
        logic [3:0] err;
        logic       done;
    } exp_t;

    exp_t       q[$];
    int         checks     = 0;
    int         errors     = 0;
    int         stray_done = 0;
    int         per_a[NCH];
    int         per_b[NCH];
    int         phase[NCH];
    bit         stuck[NCH];
    bit         use_b[NCH];
    logic [3:0] exp_sys;
    logic [3:0] exp_err;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_20M);
    endtask

    task automatic set_ch(input int c, input int a, input int b, input bit st);
        per_a[c] = a;
        per_b[c] = b;
        stuck[c] = st;
    endtask

    task automatic push_visit(input int c, input bit s, input bit e);
        exp_t it;
        exp_sys[c] = s;
        exp_err[c] = e;
        it.ch   = c;
        it.sys  = exp_sys;
        it.err  = exp_err;
        it.done = (c == NCH - 1);
        q.push_back(it);
    endtask

    task automatic push_round(input logic [3:0] s, input logic [3:0] e);
        for (int c = 0; c < NCH; c++) push_visit(c, s[c], e[c]);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk_20M);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d results still pending after budget, expected 0", name, q.size());
            q.delete();
        end
    endtask

    // Line generator: periods alternate a,b so any two consecutive periods sum to a+b.
    initial begin
        for (int c = 0; c < NCH; c++) begin
            per_a[c] = 20;
            per_b[c] = 20;
            phase[c] = c * 5;
            stuck[c] = 1'b0;
            use_b[c] = 1'b0;
        end
        bus.rxd = '0;
        forever begin
            @(negedge clk_20M);
            for (int c = 0; c < NCH; c++) begin
                int len;
                len = use_b[c] ? per_b[c] : per_a[c];
                phase[c]++;
                if (phase[c] >= len) begin
                    phase[c] = 0;
                    use_b[c] = ~use_b[c];
                    len = use_b[c] ? per_b[c] : per_a[c];
                end
                bus.rxd[c] = stuck[c] | (phase[c] < len / 2);
            end
        end
    end

    // Monitor: each channel advance presents the verdict of the channel just left.
    initial begin
        logic [1:0] last_ch;
        exp_t       it;
        last_ch = 2'd0;
        forever begin
            @(posedge clk_20M);
            #1;
            if (!reset_n) begin
                last_ch = bus.ch_sel;
            end else if (bus.ch_sel != last_ch) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_advance: ch_sel moved %0d->%0d, expected no advance", last_ch, bus.ch_sel);
                end else begin
                    it = q.pop_front();
                    chk("judged_ch", int'(last_ch), it.ch);
                    chk("next_ch", int'(bus.ch_sel), (it.ch + 1) % NCH);
                    chk("sys_Stat", int'(bus.sys_Stat), int'(it.sys));
                    chk("Pulse_err", int'(bus.Pulse_err), int'(it.err));
                    chk("scan_done", int'(bus.scan_done), int'(it.done));
                end
                last_ch = bus.ch_sel;
            end else if (bus.scan_done) begin
                stray_done++;
            end
        end
    end

    initial begin
        #(100000 * 50);
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

    initial begin
        bus.enable = 1'b0;
        reset_n    = 1'b0;
        exp_sys    = '0;
        exp_err    = '0;
        cycles(5);
        chk("rst_ch_sel", int'(bus.ch_sel), 0);
        chk("rst_sys_Stat", int'(bus.sys_Stat), 0);
        chk("rst_Pulse_err", int'(bus.Pulse_err), 0);
        chk("rst_scan_done", int'(bus.scan_done), 0);
        reset_n = 1'b1;
        cycles(3);
        bus.enable = 1'b1;

        push_round(4'b1111, 4'b0000);
        drain("t1_all_1m", 2000);

        set_ch(2, 2000, 2000, 1'b0);
        push_round(4'b1011, 4'b0000);
        drain("t2_ch2_10k", 20000);

        set_ch(1, 20, 20, 1'b1);
        push_round(4'b1001, 4'b0010);
        drain("t3_ch1_stuck", 25000);

        set_ch(1, 20, 20, 1'b0);
        set_ch(2, 20, 20, 1'b0);
        set_ch(3, 16, 17, 1'b0);
        push_round(4'b0111, 4'b1000);
        drain("t4_cnt33", 2000);

        set_ch(3, 19, 19, 1'b0);
        push_round(4'b1111, 4'b0000);
        drain("t4_cnt38", 2000);

        set_ch(3, 21, 21, 1'b0);
        push_round(4'b1111, 4'b0000);
        drain("t4_cnt42", 2000);

        set_ch(3, 18, 19, 1'b0);
        push_round(4'b0111, 4'b1000);
        drain("t4_cnt37", 2000);

        set_ch(3, 21, 22, 1'b0);
        push_round(4'b0111, 4'b1000);
        drain("t4_cnt43", 2000);

        // ch0 is in MEAS 25 cycles after the advance onto it
        set_ch(3, 20, 20, 1'b0);
        cycles(25);
        bus.enable = 1'b0;
        cycles(2);
        chk("t5_ch_sel", int'(bus.ch_sel), 0);
        chk("t5_sys_Stat", int'(bus.sys_Stat), 4'b0111);
        chk("t5_Pulse_err", int'(bus.Pulse_err), 4'b1000);
        cycles(100);
        chk("t5_ch_sel_hold", int'(bus.ch_sel), 0);
        chk("t5_sys_Stat_hold", int'(bus.sys_Stat), 4'b0111);
        bus.enable = 1'b1;
        push_round(4'b1111, 4'b0000);
        drain("t5_resume", 2000);

        push_visit(0, 1'b1, 1'b0);
        drain("t6_pre", 2000);
        cycles(25);
        reset_n = 1'b0;
        cycles(1);
        chk("t6_ch_sel", int'(bus.ch_sel), 0);
        chk("t6_sys_Stat", int'(bus.sys_Stat), 0);
        chk("t6_Pulse_err", int'(bus.Pulse_err), 0);
        chk("t6_scan_done", int'(bus.scan_done), 0);
        reset_n = 1'b1;
        exp_sys = '0;
        exp_err = '0;
        push_round(4'b1111, 4'b0000);
        drain("t6_restart", 2000);

        chk("stray_scan_done", stray_done, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
